// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: word width, address
// regions and FSM state encoding.
package dmem_responder_pkg;

  localparam int unsigned CPU_WIDTH = 32;

  localparam logic [3:0] MEM_REGION_RAM = 4'h0;
  localparam logic [3:0] MEM_REGION_PER = 4'h1;

  typedef enum logic [1:0] {
    DMR_IDLE     = 2'd0,
    DMR_PER_WAIT = 2'd1,
    DMR_RSP      = 2'd2
  } dmr_state_e;

  function automatic logic [3:0] region_of(input logic [CPU_WIDTH-1:0] addr);
    return addr[CPU_WIDTH-1:CPU_WIDTH-4];
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous word RAM with write-through read port.
// Written in the plain template that maps onto block RAM.
module dmem_ram #(
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
        rdata     <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: RAM region served locally, peripheral region
// forwarded over req/ack with timeout, everything else answers a bus error.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned RAM_DEPTH = 4096,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 data_mem_req_i,
  input  logic                 data_mem_wr_en_i,
  input  logic [CPU_WIDTH-1:0] data_mem_addr_i,
  input  logic [CPU_WIDTH-1:0] data_mem_data_i,
  output logic [CPU_WIDTH-1:0] data_mem_data_o,
  output logic                 rsp_valid_o,
  output logic                 busy_o,
  output logic                 bus_err_o,
  output logic                 per_req_o,
  output logic                 per_we_o,
  output logic [CPU_WIDTH-1:0] per_addr_o,
  output logic [CPU_WIDTH-1:0] per_wdata_o,
  input  logic [CPU_WIDTH-1:0] per_rdata_i,
  input  logic                 per_ack_i
);

  localparam int unsigned AW    = $clog2(RAM_DEPTH);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  dmr_state_e           state_q;
  logic                 rsp_valid_q;
  logic                 bus_err_q;
  logic                 err_q;
  logic                 per_req_q;
  logic                 per_we_q;
  logic [CPU_WIDTH-1:0] per_addr_q;
  logic [CPU_WIDTH-1:0] per_wdata_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CPU_WIDTH-1:0] data_q;
  logic                 sel_ram_q;

  logic                 accept;
  logic [3:0]           region;
  logic                 ram_en;
  logic [CPU_WIDTH-1:0] ram_rdata;
  logic                 addr_lsb_unused;

  assign accept          = (state_q == DMR_IDLE) && data_mem_req_i;
  assign region          = region_of(data_mem_addr_i);
  assign ram_en          = accept && (region == MEM_REGION_RAM);
  assign addr_lsb_unused = ^data_mem_addr_i[1:0];

  dmem_ram #(
    .DEPTH (RAM_DEPTH),
    .WIDTH (CPU_WIDTH)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (data_mem_wr_en_i),
    .addr  (data_mem_addr_i[AW+1:2]),
    .wdata (data_mem_data_i),
    .rdata (ram_rdata)
  );

  // The read-data register is split: RAM responses come straight from the
  // RAM's own output register, all others from data_q; sel_ram_q picks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= DMR_IDLE;
      rsp_valid_q <= 1'b0;
      bus_err_q   <= 1'b0;
      err_q       <= 1'b0;
      per_req_q   <= 1'b0;
      per_we_q    <= 1'b0;
      per_addr_q  <= '0;
      per_wdata_q <= '0;
      cnt_q       <= '0;
      data_q      <= '0;
      sel_ram_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      bus_err_q   <= 1'b0;
      case (state_q)
        DMR_IDLE: begin
          if (accept) begin
            case (region)
              MEM_REGION_RAM: begin
                sel_ram_q   <= 1'b1;
                rsp_valid_q <= 1'b1;
              end
              MEM_REGION_PER: begin
                per_we_q    <= data_mem_wr_en_i;
                per_addr_q  <= {data_mem_addr_i[CPU_WIDTH-1:2], 2'b00};
                per_wdata_q <= data_mem_data_i;
                per_req_q   <= 1'b1;
                cnt_q       <= '0;
                err_q       <= 1'b0;
                state_q     <= DMR_PER_WAIT;
              end
              default: begin
                data_q      <= '0;
                sel_ram_q   <= 1'b0;
                rsp_valid_q <= 1'b1;
                bus_err_q   <= 1'b1;
              end
            endcase
          end
        end
        DMR_PER_WAIT: begin
          if (per_ack_i) begin
            per_req_q <= 1'b0;
            if (!per_we_q) begin
              data_q    <= per_rdata_i;
              sel_ram_q <= 1'b0;
            end
            state_q <= DMR_RSP;
          end else if (cnt_q == CNT_MAX) begin
            per_req_q <= 1'b0;
            data_q    <= '0;
            sel_ram_q <= 1'b0;
            err_q     <= 1'b1;
            state_q   <= DMR_RSP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DMR_RSP: begin
          rsp_valid_q <= 1'b1;
          bus_err_q   <= err_q;
          state_q     <= DMR_IDLE;
        end
        default: state_q <= DMR_IDLE;
      endcase
    end
  end

  assign data_mem_data_o = sel_ram_q ? ram_rdata : data_q;
  assign rsp_valid_o     = rsp_valid_q;
  assign bus_err_o       = bus_err_q;
  assign busy_o          = (state_q != DMR_IDLE);
  assign per_req_o       = per_req_q;
  assign per_we_o        = per_we_q;
  assign per_addr_o      = per_addr_q;
  assign per_wdata_o     = per_wdata_q;

endmodule
